// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function selects, flag indices and sequencer states
package alu_pkg;

  localparam logic [4:0] ALU_PASSA16 = 5'b10000;
  localparam logic [4:0] ALU_ADD16   = 5'b10100;
  localparam logic [4:0] ALU_LSL16   = 5'b11011;

  // Flag vector is {Z,C,N,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-add multiplier driving the 16-bit ALU
// Alternates an ADD (P += Q[0] ? M : 0) with an LSL of M until all multiplier bits are used.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int OPW        = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OPW-1:0]  OpA,
  input  logic [OPW-1:0]  OpB,
  output logic            Busy,
  output logic            Done,
  output logic [15:0]     Product,
  output logic [15:0]     AluA,
  output logic [15:0]     AluB,
  output logic [4:0]      AluFunSel,
  output logic            AluWF,
  input  logic [15:0]     AluOut,
  input  logic [3:0]      AluFlags
);

  seq_state_t     state;
  logic [15:0]    p;
  logic [15:0]    m;
  logic [OPW-1:0] q;
  logic [3:0]     count;
  logic           last_iter;
  logic [3:0]     flags_unused;

  // Flags are only observed by the datapath owner, never used for sequencing.
  assign flags_unused = AluFlags;

  assign last_iter = (count + 4'd1 == 4'(OPW)) ||
                     (EARLY_EXIT && ((q >> 1) == '0));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= 16'd0;
      p       <= 16'd0;
      m       <= 16'd0;
      q       <= '0;
      count   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            p     <= 16'd0;
            m     <= {{(16-OPW){1'b0}}, OpA};
            q     <= OpB;
            count <= 4'd0;
            Busy  <= 1'b1;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          p     <= AluOut;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          m     <= AluOut;
          q     <= q >> 1;
          count <= count + 4'd1;
          if (last_iter) begin
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Product <= p;
            state   <= S_DONE;
          end else begin
            state <= S_ADD;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    AluFunSel = ALU_PASSA16;
    AluA      = 16'd0;
    AluB      = 16'd0;
    AluWF     = 1'b0;
    case (state)
      S_ADD: begin
        AluFunSel = ALU_ADD16;
        AluA      = p;
        AluB      = q[0] ? m : 16'd0;
        AluWF     = 1'b1;
      end
      S_SHIFT: begin
        AluFunSel = ALU_LSL16;
        AluA      = m;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - checks the sequencer against a product/latency model
// Instance 0 runs with EARLY_EXIT=0, instance 1 with EARLY_EXIT=1; each drives its own ALU model.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        start_v   [2];
  logic [7:0]  opa_v     [2];
  logic [7:0]  opb_v     [2];
  logic        busy_v    [2];
  logic        done_v    [2];
  logic [15:0] product_v [2];
  logic [15:0] alua_v    [2];
  logic [15:0] alub_v    [2];
  logic [4:0]  alufs_v   [2];
  logic        aluwf_v   [2];
  logic [15:0] aluout_v  [2];
  logic [3:0]  aluflags_v[2];

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  // Behavioural model state: busy cycles left, done pulse, product register
  int          m_left   [2];
  bit          m_done   [2];
  logic [15:0] m_prod   [2];
  logic [15:0] m_pend   [2];

  always #5 Clock = ~Clock;

  // Returns {flags, result} for the subset of ALU functions the sequencer uses.
  function automatic logic [19:0] alu_f(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [3:0]  f;
    s = 17'd0;
    f = 4'd0;
    case (fs)
      ALU_ADD16: begin
        s = {1'b0, a} + {1'b0, b};
        f[FLAG_C] = s[16];
        f[FLAG_O] = (a[15] == b[15]) && (s[15] != a[15]);
      end
      ALU_LSL16: begin
        s = {1'b0, a << 1};
        f[FLAG_C] = a[15];
      end
      default: s = {1'b0, a};
    endcase
    f[FLAG_Z] = (s[15:0] == 16'd0);
    f[FLAG_N] = s[15];
    return {f, s[15:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [19:0] res;
    assign res = alu_f(alufs_v[g], alua_v[g], alub_v[g]);
    assign aluout_v[g] = res[15:0];
    always @(posedge Clock) if (aluwf_v[g]) aluflags_v[g] <= res[19:16];

    alu_mul_sequencer #(.OPW(8), .EARLY_EXIT(g == 1)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (start_v[g]),
      .OpA      (opa_v[g]),
      .OpB      (opb_v[g]),
      .Busy     (busy_v[g]),
      .Done     (done_v[g]),
      .Product  (product_v[g]),
      .AluA     (alua_v[g]),
      .AluB     (alub_v[g]),
      .AluFunSel(alufs_v[g]),
      .AluWF    (aluwf_v[g]),
      .AluOut   (aluout_v[g]),
      .AluFlags (aluflags_v[g])
    );
  end

  function automatic int latency(input int inst, input logic [7:0] b);
    int k;
    if (inst == 0) return 16;
    k = 1;
    for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
    return 2 * k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
        m_prod[i] = 16'd0;
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_done[i] = 1'b1;
          m_prod[i] = m_pend[i];
        end
      end else if (start_v[i]) begin
        m_left[i] = latency(i, opb_v[i]);
        m_pend[i] = 16'(opa_v[i]) * 16'(opb_v[i]);
      end
    end
  end

  always @(negedge Clock) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(m_left[i] > 0));
        chk($sformatf("done%0d", i), 32'(done_v[i]), 32'(m_done[i]));
        chk($sformatf("product%0d", i), 32'(product_v[i]), 32'(m_prod[i]));
        if (m_done[i])
          chk($sformatf("zflag%0d", i), 32'(aluflags_v[i][FLAG_Z]), 32'(m_prod[i] == 16'd0));
        if (m_left[i] == 0) begin
          chk($sformatf("idle_funsel%0d", i), 32'(alufs_v[i]), 32'(ALU_PASSA16));
          chk($sformatf("idle_wf%0d", i), 32'(aluwf_v[i]), 32'd0);
          chk($sformatf("idle_ab%0d", i), {alua_v[i], alub_v[i]}, 32'd0);
        end
      end
    end
  end

  // Issues one Start and counts cycles until Done; optional re-pulses and a mid-op reset.
  task automatic run_op(input int inst, input int a, input int b, input int rep1, input int rep2,
                        input int rst_at, output int n, output int bn);
    @(negedge Clock);
    opa_v[inst] = 8'(a);
    opb_v[inst] = 8'(b);
    start_v[inst] = 1'b1;
    @(negedge Clock);
    start_v[inst] = 1'b0;
    n = 1;
    bn = busy_v[inst] ? 1 : 0;
    while (!done_v[inst] && n < 100) begin
      start_v[inst] = (n == rep1 || n == rep2);
      if (n == rst_at) Reset = 1'b1;
      @(negedge Clock);
      n++;
      if (Reset) begin
        Reset = 1'b0;
        start_v[inst] = 1'b0;
        return;
      end
      if (busy_v[inst]) bn++;
    end
    start_v[inst] = 1'b0;
    if (!done_v[inst]) chk("done_timeout", 32'(n), 32'd0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge Clock);
  endtask

  initial begin
    int n, bn;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      opa_v[i] = 8'd0;
      opb_v[i] = 8'd0;
      m_left[i] = 0;
      m_done[i] = 1'b0;
      m_prod[i] = 16'd0;
      m_pend[i] = 16'd0;
    end
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    chk("reset_busy", 32'(busy_v[0]), 32'd0);
    chk("reset_done", 32'(done_v[0]), 32'd0);
    chk("reset_product", 32'(product_v[0]), 32'd0);
    armed = 1'b1;

    run_op(0, 13, 11, -1, -1, -1, n, bn);
    chk("t1_done_cycle", 32'(n), 32'd17);
    chk("t1_busy_cycles", 32'(bn), 32'd16);
    chk("t1_product", 32'(product_v[0]), 32'h008F);
    chk("t1_zflag", 32'(aluflags_v[0][FLAG_Z]), 32'd0);
    idle(3);

    run_op(0, 255, 255, -1, -1, -1, n, bn);
    chk("t2_product", 32'(product_v[0]), 32'hFE01);
    chk("t2_busy_cycles", 32'(bn), 32'd16);
    idle(2);

    run_op(0, 0, 200, -1, -1, -1, n, bn);
    chk("t3_product", 32'(product_v[0]), 32'd0);
    chk("t3_zflag", 32'(aluflags_v[0][FLAG_Z]), 32'd1);
    idle(2);

    run_op(0, 7, 9, 3, 10, -1, n, bn);
    chk("t4_product", 32'(product_v[0]), 32'd63);
    chk("t4_done_cycle", 32'(n), 32'd17);
    idle(20);
    chk("t4_no_second_busy", 32'(busy_v[0]), 32'd0);

    run_op(0, 5, 6, -1, -1, 5, n, bn);
    chk("t5_reset_busy", 32'(busy_v[0]), 32'd0);
    chk("t5_reset_product", 32'(product_v[0]), 32'd0);
    chk("t5_reset_done", 32'(done_v[0]), 32'd0);
    idle(2);
    run_op(0, 3, 4, -1, -1, -1, n, bn);
    chk("t5_product", 32'(product_v[0]), 32'd12);
    idle(2);

    run_op(1, 100, 1, -1, -1, -1, n, bn);
    chk("t6_done_cycle", 32'(n), 32'd3);
    chk("t6_busy_cycles", 32'(bn), 32'd2);
    chk("t6_product", 32'(product_v[1]), 32'd100);
    idle(2);
    run_op(1, 77, 0, -1, -1, -1, n, bn);
    chk("t7_busy_cycles", 32'(bn), 32'd2);
    chk("t7_product", 32'(product_v[1]), 32'd0);
    idle(2);
    run_op(1, 3, 5, -1, -1, -1, n, bn);
    chk("t8_busy_cycles", 32'(bn), 32'd6);
    chk("t8_product", 32'(product_v[1]), 32'd15);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
